// File: rtl/decoder38_hold.sv
// Sequenced 3-to-8 one-hot decoder: codes arrive through a valid/ready FIFO and
// each one drives its one-hot line on y for HOLD_CYCLES clock periods.
module decoder38_hold #(
    parameter int HOLD_CYCLES = 10,
    parameter int DEPTH       = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [2:0]               D,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     clr,
    output logic [7:0]               y,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int          PW     = $clog2(DEPTH);
    localparam int          LW     = PW + 1;
    localparam logic [15:0] RELOAD = 16'(HOLD_CYCLES - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    logic [0:0]    state;
    logic [15:0]   cnt;
    logic [2:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    // Ready comes straight from the registered level so it never depends on a pop.
    assign full     = (level == LW'(DEPTH));
    assign empty    = (level == '0);
    assign in_ready = !full;

    assign push = in_valid && !full && !clr;
    assign pop  = !empty && !clr && ((state == IDLE) || (cnt == 16'd0));

    assign busy = (state == HOLD);
    assign done = (state == HOLD) && (cnt == 16'd0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= D;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            y      <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clr) begin
            state  <= IDLE;
            cnt    <= '0;
            y      <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase

            // A pop at the end of a hold reloads directly, so streaming codes leave no gap.
            if (pop) begin
                state <= HOLD;
                y     <= 8'd1 << mem[rd_ptr];
                cnt   <= RELOAD;
            end else if (state == HOLD) begin
                if (cnt != 16'd0) begin
                    cnt <= cnt - 16'd1;
                end else begin
                    state <= IDLE;
                    y     <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_decoder38_hold.sv
// Directed bench for decoder38_hold: instance A (HOLD_CYCLES=4, DEPTH=4) for
// timing, full/wrap and flush; instance B (HOLD_CYCLES=1) for encoder round-trip.
module tb_decoder38_hold;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] d_a, d_b;
    logic       in_valid_a, in_valid_b;
    logic       clr_a, clr_b;
    logic       in_ready_a, in_ready_b;
    logic [7:0] y_a, y_b;
    logic       busy_a, busy_b;
    logic       done_a, done_b;
    logic [2:0] level_a, level_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decoder38_hold #(.HOLD_CYCLES(4), .DEPTH(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .D(d_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .clr(clr_a), .y(y_a), .busy(busy_a), .done(done_a), .level(level_a)
    );

    decoder38_hold #(.HOLD_CYCLES(1), .DEPTH(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .D(d_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .clr(clr_b), .y(y_b), .busy(busy_b), .done(done_b), .level(level_b)
    );

    // Stand-in for the far-side 8:3 encoder.
    function automatic logic [2:0] encode(input logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            if (v[i]) return 3'(i);
        end
        return 3'd0;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid_a = 1'b1; d_a = 3'd5; clr_a = 1'b0;
        in_valid_b = 1'b1; d_b = 3'd5; clr_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checks++;
            if (y_a !== 8'h00 || busy_a !== 1'b0 || level_a !== 3'd0 || in_ready_a !== 1'b1 || done_a !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_a y=%h busy=%b level=%0d ready=%b done=%b want y=00 busy=0 level=0 ready=1 done=0",
                         y_a, busy_a, level_a, in_ready_a, done_a);
            end
        end
        checks++;
        if (y_b !== 8'h00 || busy_b !== 1'b0 || level_b !== 3'd0 || in_ready_b !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_b y=%h busy=%b level=%0d ready=%b want y=00 busy=0 level=0 ready=1",
                     y_b, busy_b, level_b, in_ready_b);
        end
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        logic [7:0] exp_y;
        d_a = 3'd3; in_valid_a = 1'b1;
        @(posedge clk); #1;
        in_valid_a = 1'b0;
        checks++;
        if (level_a !== 3'd1 || y_a !== 8'h00) begin
            errors++;
            $display("[TB] FAIL single_accept level=%0d y=%h want level=1 y=00", level_a, y_a);
        end
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            exp_y = (k <= 4) ? 8'h08 : 8'h00;
            checks++;
            if (y_a !== exp_y || busy_a !== (k <= 4) || done_a !== (k == 4)) begin
                errors++;
                $display("[TB] FAIL single_cycle%0d y=%h busy=%b done=%b want y=%h busy=%b done=%b",
                         k, y_a, busy_a, done_a, exp_y, (k <= 4), (k == 4));
            end
        end
    endtask

    task automatic test_sweep();
        int         idx = 0;
        int         dones = 0;
        logic       rdy_prev;
        logic [7:0] exp_y;
        logic       exp_done;
        in_valid_a = 1'b1; d_a = 3'd0; rdy_prev = in_ready_a;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (in_valid_a && rdy_prev) idx++;
            in_valid_a = (idx < 8);
            d_a = 3'(idx);
            rdy_prev = in_ready_a;
            exp_y    = (c >= 2 && c <= 33) ? (8'd1 << ((c - 2) / 4)) : 8'h00;
            exp_done = (c >= 2 && c <= 33 && ((c - 2) % 4) == 3);
            if (done_a) dones++;
            checks++;
            if (y_a !== exp_y || done_a !== exp_done) begin
                errors++;
                $display("[TB] FAIL sweep_c%0d y=%h done=%b want y=%h done=%b", c, y_a, done_a, exp_y, exp_done);
            end
        end
        in_valid_a = 1'b0;
        checks++;
        if (idx != 8 || dones != 8) begin
            errors++;
            $display("[TB] FAIL sweep_totals accepted=%0d dones=%0d want 8 and 8", idx, dones);
        end
    endtask

    task automatic test_full_wrap();
        logic [2:0] codes [6] = '{3'd5, 3'd2, 3'd7, 3'd1, 3'd6, 3'd3};
        logic [7:0] got [6];
        int         idx = 0;
        int         dones = 0;
        logic       rdy_prev;
        in_valid_a = 1'b1; d_a = codes[0]; rdy_prev = in_ready_a;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            if (in_valid_a && rdy_prev) idx++;
            in_valid_a = (idx < 6);
            d_a = (idx < 6) ? codes[idx] : 3'd0;
            rdy_prev = in_ready_a;
            if (done_a) begin
                if (dones < 6) got[dones] = y_a;
                dones++;
            end
            if (c == 5 || c == 7) begin
                checks++;
                if (level_a !== 3'd4 || in_ready_a !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL full_c%0d level=%0d ready=%b want level=4 ready=0", c, level_a, in_ready_a);
                end
            end
            if (c == 6) begin
                checks++;
                if (level_a !== 3'd3 || in_ready_a !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL unfull_c6 level=%0d ready=%b want level=3 ready=1", level_a, in_ready_a);
                end
            end
        end
        checks++;
        if (dones != 6) begin
            errors++;
            $display("[TB] FAIL wrap_dones got=%0d want 6", dones);
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (dones < 6 || got[i] !== (8'd1 << codes[i])) begin
                errors++;
                $display("[TB] FAIL wrap_order%0d y=%h want %h", i, got[i], 8'd1 << codes[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic stray = 1'b0;
        in_valid_a = 1'b1; d_a = 3'd1;
        @(posedge clk); #1; d_a = 3'd4;
        @(posedge clk); #1; d_a = 3'd6;
        @(posedge clk); #1; in_valid_a = 1'b0;
        checks++;
        if (y_a !== 8'h02 || busy_a !== 1'b1 || level_a !== 3'd2) begin
            errors++;
            $display("[TB] FAIL pre_reset y=%h busy=%b level=%0d want y=02 busy=1 level=2", y_a, busy_a, level_a);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (y_a !== 8'h00 || busy_a !== 1'b0 || level_a !== 3'd0 || in_ready_a !== 1'b1) begin
            errors++;
            $display("[TB] FAIL async_reset y=%h busy=%b level=%0d ready=%b want y=00 busy=0 level=0 ready=1",
                     y_a, busy_a, level_a, in_ready_a);
        end
        #1 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (y_a !== 8'h00 || busy_a !== 1'b0) stray = 1'b1;
        end
        checks++;
        if (stray) begin
            errors++;
            $display("[TB] FAIL post_reset_output stray=%b want 0", stray);
        end
    endtask

    task automatic test_clr();
        logic stray = 1'b0;
        in_valid_a = 1'b1; d_a = 3'd3;
        @(posedge clk); #1; d_a = 3'd0;
        @(posedge clk); #1;
        checks++;
        if (y_a !== 8'h08 || level_a !== 3'd1) begin
            errors++;
            $display("[TB] FAIL pre_clr y=%h level=%0d want y=08 level=1", y_a, level_a);
        end
        clr_a = 1'b1; in_valid_a = 1'b1; d_a = 3'd4;
        @(posedge clk); #1;
        clr_a = 1'b0; in_valid_a = 1'b0;
        checks++;
        if (y_a !== 8'h00 || busy_a !== 1'b0 || level_a !== 3'd0 || done_a !== 1'b0 || in_ready_a !== 1'b1) begin
            errors++;
            $display("[TB] FAIL clr_flush y=%h busy=%b level=%0d done=%b ready=%b want 00 0 0 0 1",
                     y_a, busy_a, level_a, done_a, in_ready_a);
        end
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (y_a !== 8'h00 || busy_a !== 1'b0) stray = 1'b1;
        end
        checks++;
        if (stray) begin
            errors++;
            $display("[TB] FAIL clr_drop stray=%b want 0", stray);
        end
    endtask

    task automatic test_round_trip();
        logic [2:0] sent [$];
        logic [2:0] exp_code;
        int         n_sent = 0;
        int         n_got = 0;
        logic       rdy_prev;
        in_valid_b = 1'b1; d_b = 3'($urandom_range(0, 7)); rdy_prev = in_ready_b;
        for (int c = 0; c < 200 && n_got < 20; c++) begin
            @(posedge clk); #1;
            if (in_valid_b && rdy_prev) begin
                sent.push_back(d_b);
                n_sent++;
            end
            in_valid_b = (n_sent < 20);
            d_b = 3'($urandom_range(0, 7));
            rdy_prev = in_ready_b;
            if (busy_b) begin
                checks++;
                if (sent.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL trip_extra y=%h want no output", y_b);
                end else begin
                    exp_code = sent.pop_front();
                    if (!$onehot(y_b) || encode(y_b) !== exp_code || done_b !== 1'b1) begin
                        errors++;
                        $display("[TB] FAIL trip%0d y=%h code=%0d done=%b want code=%0d done=1",
                                 n_got, y_b, encode(y_b), done_b, exp_code);
                    end
                end
                n_got++;
            end
        end
        in_valid_b = 1'b0;
        checks++;
        if (n_got != 20) begin
            errors++;
            $display("[TB] FAIL trip_count got=%0d want 20", n_got);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_sweep();
        test_full_wrap();
        test_reset_mid();
        test_clr();
        test_round_trip();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decoder38_hold.md
# decoder38_hold

Sequenced 3-to-8 one-hot decoder. It accepts 3-bit codes through a valid/ready handshake and buffers them in a small FIFO. Each code drives the matching one-hot line on `y` for a fixed number of clock cycles. It is the drive-side counterpart of the 8:3 encoder and produces timed one-hot patterns, for example an 8-line stimulus sweep or LED/row select, that an encoder on the far side turns back into codes.

## Interface
- `HOLD_CYCLES`, default 10: cycles each one-hot value is held on `y`; legal range 1..65535.
- `DEPTH`, default 4: code FIFO depth; power of two, 2..16.
- `clk` input 1: system clock, rising-edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `D` input 3: code to decode, index of the line to assert.
- `in_valid` input 1: `D` is valid this cycle.
- `in_ready` output 1: FIFO can accept a code; equals !full.
- `clr` input 1: synchronous flush of FIFO and hold state.
- `y` output 8: one-hot decoded output; all-zero when idle.
- `busy` output 1: a code is currently being held on `y`.
- `done` output 1: high during the final cycle of each hold.
- `level` output $clog2(DEPTH)+1: number of codes queued in the FIFO.

## Operation
- Accept: a code is accepted on a rising edge where `in_valid` && `in_ready`. `D` is written to the FIFO tail and `level` increments.
- FSM states:
  - IDLE: `y`=0 and `busy`=0. If the FIFO is non-empty, pop the head, load `y` = 8'b1 << code, load `cnt` = HOLD_CYCLES-1, then go to HOLD.
  - HOLD: `busy`=1 and `y` stays constant.
    - If `cnt` != 0, decrement `cnt`.
    - If `cnt` == 0 and the FIFO is non-empty, pop the next code, reload `y` and `cnt`, and stay in HOLD. There is no gap cycle.
    - If `cnt` == 0 and the FIFO is empty, go to IDLE; `y` is 0 from the next cycle.
- `done` = (state == HOLD) && (`cnt` == 0), registered-state decode. There is exactly one `done` cycle per decoded code.
- Push and pop in the same edge: allowed whenever not full; `level` is unchanged.
- Full FIFO: `in_ready`=0 even if a pop occurs the same cycle. The ready path does not depend on the pop.
- `clr`: synchronous flush, priority over all other activity.
  - Empties the FIFO, forces IDLE, sets `y`=0 and `cnt`=0.
  - Any code presented on the same edge is dropped.
- FIFO pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH. `level` is the full/empty discriminator.
- `cnt` is 16 bits, unsigned, and never underflows.

## Timing
- Reset (`rst_n`=0, async): state=IDLE, `y`=8'h00, `busy`=0, `done`=0, `level`=0, `in_ready`=1, `cnt`=0.
  - Deassertion is synchronous to `clk` by the system reset synchronizer.
- Latency: code accepted at edge N into an empty FIFO while IDLE gives `y` valid after edge N+1.
- Hold length: `y` holds each value for exactly HOLD_CYCLES clock periods.
- Back-to-back codes produce one-hot changes every HOLD_CYCLES cycles with no zero cycle between them.
- HOLD_CYCLES=1: `done` is continuously high while streaming, and `y` changes every cycle.
- `in_ready` falls in the cycle after the edge that makes `level`==DEPTH. It rises the cycle after the pop that clears full.
- Reset asserted mid-hold: all outputs go to reset values immediately, without waiting for `clk`. Queued codes are lost.
- All outputs are registered or decoded from registers; there are no combinational input-to-output paths.

## Test plan
- Reset: hold `rst_n`=0 with `in_valid`=1 and `D`=5 -> `y`=0, `busy`=0, `level`=0, `in_ready`=1 throughout.
- Single code, HOLD_CYCLES=4: push `D`=3 at edge N -> `y`=8'b00001000 for edges N+1..N+4, `done` high in the 4th cycle, then `y`=0 and `busy`=0.
- Sweep: push `D`=0..7 back-to-back honoring `in_ready` -> `y` walks 01,02,04,...,80 with each value held exactly HOLD_CYCLES cycles, no zero gaps, and 8 `done` pulses.
- Full/wrap, DEPTH=4: push 6 codes with `in_valid` held high during one long hold.
  - Required: `in_ready`=0 once `level`=4.
  - Required: stalled codes are accepted after pops, and output order equals input order across pointer wrap.
- Reset and `clr` mid-hold:
  - `rst_n` pulse at `cnt`=2 with 2 codes queued -> `y`=0 asynchronously, and no further output after release.
  - `clr` with `in_valid`=1 -> same flush, and that edge's code is dropped.
- Round-trip: feed `y` to the team's 8:3 encoder while streaming random codes with HOLD_CYCLES=1 -> encoded value equals each pushed `D`, in order.
